packet_parser: RTL and testbench
================================

Name: packet_parser

Overview:
- Receive side of the packet_gen word stream: consumes 32-bit packet words on a valid strobe, recovers the header metadata, and checks payload integrity and destination.
- Emits one metadata word per packet, with an error flag, for the egress buffer / software read path.
- Keeps saturating good and bad packet counters for the hw_sw_interface.
- One instance sits on each switch output port.

Parameters:
- PORT_ID, 2'd0, this output port's index; compared to the header dst field.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pkt_valid  input  1  pkt_data holds a packet word this cycle (packet_ready of packet_gen)
- pkt_data  input  32  packet word
- meta_valid  output  1  one-cycle pulse: meta_out/meta_err valid
- meta_out  output  32  recovered header word of the completed packet
- meta_err  output  1  completed packet failed a check
- busy  output  1  mid-packet (state PAYLOAD)
- pkt_count  output  CNT_W  packets completed, saturating
- err_count  output  CNT_W  packets completed with error, saturating

Behaviour:
- Packet format (shared package, fixed):
  - Word 0 is the header: [31:30] src, [29:28] dst, [27:20] len (payload words, 0..255), [19:0] seq.
  - Payload word k (k = 0..len-1) = {header[15:0], k[15:0]}.
- Only pkt_valid=1 cycles carry words; gaps of any length are allowed anywhere, with no timeout. There is no backpressure; every valid word is consumed.
- Reset (synchronous): state=IDLE; meta_valid=0, meta_out=0, meta_err=0, busy=0, pkt_count=0, err_count=0; internal hdr, idx and err registers cleared.
- FSM IDLE:
  - On a valid word: latch it as hdr; set err = (dst != PORT_ID); clear idx.
  - If len==0, go to DONE; otherwise go to PAYLOAD.
- FSM PAYLOAD:
  - On a valid word: compare against {hdr[15:0], idx[15:0]}; any mismatch sets err (sticky for the packet); increment idx.
  - When the word with idx==len-1 is accepted, go to DONE.
- FSM DONE:
  - One cycle: meta_valid=1, meta_out=hdr, meta_err=err.
  - pkt_count+1; err_count+1 if err; both saturate at all-ones.
  - Return to IDLE.
  - A valid word arriving in DONE is a header: it is latched exactly as in IDLE, and the next state is PAYLOAD, or DONE if its len==0. Back-to-back packets therefore lose no words.
- Latency: meta_valid asserts exactly 1 cycle after the last word of the packet (the header, for len==0) is accepted.
- meta_out and meta_err hold their value between pulses; meta_valid is 0 outside DONE.
- busy = (state==PAYLOAD).
- A mismatched payload word still counts toward len; length is defined by the header only.
- idx is 8 bits and is zero-extended to 16 bits for the compare.
- Reset mid-packet: the partial packet is discarded, no meta_valid is issued, and the counters clear.

Decomposition:
- Package switch_pkg (switch_defs.svh) holds:
  - the header field typedef (packed struct src, dst, len, seq);
  - LEN_W=8, SEQ_W=20;
  - the payload-word construction function, shared with packet_gen;
  - the state enum {IDLE, PAYLOAD, DONE}.
- One natural sub-module: sat_counter (CNT_W, inc input), instantiated twice for pkt_count and err_count.

Test Plan:
- Header 32'h0030_0005 (src0, dst0, len3, seq5), payloads 32'h0005_0000, 32'h0005_0001, 32'h0005_0002, PORT_ID=0 -> one meta_valid pulse 1 cycle after the last word; meta_out=32'h0030_0005; meta_err=0; pkt_count=1; err_count=0.
- Same packet with payload 1 = 32'h0005_00FF -> meta_err=1; err_count=1; pulse timing unchanged.
- Header with dst=2 (32'h2010_0001, len1) to PORT_ID=0 with a correct payload -> meta_err=1.
- Back-to-back: packet A (len0, header only) immediately followed by packet B (len2), no gaps -> two pulses, 1 cycle after A's header and 1 cycle after B's last word; pkt_count=2.
- Random pkt_valid gaps (0–5 cycles) inside a len=255 packet -> single pulse, meta_err=0, busy high from header+1 until the last word.
- reset asserted after 2 of 4 payload words, then a fresh len1 packet -> no pulse for the aborted packet; pkt_count=1 after the fresh packet; counters force-preloaded near all-ones saturate at all-ones.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: definitions shared by packet_gen and packet_parser.
//   hdr_t        - header word layout {src, dst, len, seq}
//   LEN_W, SEQ_W - widths of the len and seq header fields
//   payload_word - builds payload word k of a packet from its header
//   state_t      - parser FSM states
package switch_pkg;

    localparam int LEN_W = 8;
    localparam int SEQ_W = 20;

    typedef struct packed {
        logic [1:0]       src;
        logic [1:0]       dst;
        logic [LEN_W-1:0] len;
        logic [SEQ_W-1:0] seq;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DONE
    } state_t;

    // Payload word k = {header[15:0], k zero-extended to 16 bits}.
    function automatic logic [31:0] payload_word(input hdr_t hdr, input logic [LEN_W-1:0] k);
        logic [31:0] hdr_bits;
        hdr_bits = hdr;
        return {hdr_bits[15:0], {(16 - LEN_W){1'b0}}, k};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at all-ones.
//   clk   - system clock
//   reset - synchronous, active-high; clears the count
//   inc   - add one this cycle (ignored once saturated)
//   count - current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/packet_parser.sv
// packet_parser: receive side of the packet word stream for one switch
// output port. Latches the header, checks every payload word against the
// expected pattern and the destination against PORT_ID, then emits one
// metadata pulse per packet and keeps saturating good/bad counters.
//   clk, reset  - system clock, synchronous active-high reset
//   pkt_valid   - pkt_data carries a packet word this cycle
//   pkt_data    - packet word (header first, then len payload words)
//   meta_valid  - one-cycle pulse, meta_out/meta_err valid
//   meta_out    - header word of the completed packet (held between pulses)
//   meta_err    - completed packet failed a check (held between pulses)
//   busy        - parser is inside a packet payload
//   pkt_count   - packets completed, saturating
//   err_count   - packets completed with error, saturating
module packet_parser
    import switch_pkg::*;
#(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [31:0]      pkt_data,
    output logic             meta_valid,
    output logic [31:0]      meta_out,
    output logic             meta_err,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    state_t           state_reg, state_next;
    hdr_t             hdr_reg, hdr_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic             err_reg, err_next;
    logic             enter_done;
    logic             meta_valid_reg;
    logic [31:0]      meta_out_reg;
    logic             meta_err_reg;
    hdr_t             hdr_in;

    assign hdr_in = hdr_t'(pkt_data);

    always_comb begin
        state_next = state_reg;
        hdr_next   = hdr_reg;
        idx_next   = idx_reg;
        err_next   = err_reg;
        enter_done = 1'b0;
        case (state_reg)
            // DONE lasts one cycle but still accepts a header, so
            // back-to-back packets lose no words.
            IDLE, DONE: begin
                state_next = IDLE;
                if (pkt_valid) begin
                    hdr_next = hdr_in;
                    err_next = (hdr_in.dst != PORT_ID);
                    idx_next = '0;
                    if (hdr_in.len == '0) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pkt_valid) begin
                    // Error is sticky; a bad word still counts toward len.
                    if (pkt_data != payload_word(hdr_reg, idx_reg)) begin
                        err_next = 1'b1;
                    end
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == hdr_reg.len - 1'b1) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            hdr_reg        <= '0;
            idx_reg        <= '0;
            err_reg        <= 1'b0;
            meta_valid_reg <= 1'b0;
            meta_out_reg   <= '0;
            meta_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hdr_reg        <= hdr_next;
            idx_reg        <= idx_next;
            err_reg        <= err_next;
            // Outputs are loaded on the transition into DONE so they are
            // registered and valid for exactly the DONE cycle.
            meta_valid_reg <= enter_done;
            if (enter_done) begin
                meta_out_reg <= hdr_next;
                meta_err_reg <= err_next;
            end
        end
    end

    // Counters step on the same edge that raises meta_valid, so the
    // counts seen alongside the pulse already include that packet.
    sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (enter_done),
        .count (pkt_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (enter_done && err_next),
        .count (err_count)
    );

    assign meta_valid = meta_valid_reg;
    assign meta_out   = meta_out_reg;
    assign meta_err   = meta_err_reg;
    assign busy       = (state_reg == PAYLOAD);

endmodule

// File: tb/tb_packet_parser.sv
// Testbench for packet_parser: directed packets, expected metadata pushed
// into a scoreboard queue by the driver and popped by a monitor on every
// meta_valid pulse. A second narrow-counter instance covers saturation.
module tb_packet_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [31:0] pkt_data = '0;
    logic        meta_valid;
    logic [31:0] meta_out;
    logic        meta_err;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_meta_valid;
    logic [31:0] s_meta_out;
    logic        s_meta_err;
    logic        s_busy;
    logic [2:0]  s_pkt;
    logic [2:0]  s_err;

    always #5 clk = ~clk;

    packet_parser #(.PORT_ID(2'd0), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .meta_valid (meta_valid),
        .meta_out   (meta_out),
        .meta_err   (meta_err),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    packet_parser #(.PORT_ID(2'd1), .CNT_W(3)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (s_valid),
        .pkt_data   (s_data),
        .meta_valid (s_meta_valid),
        .meta_out   (s_meta_out),
        .meta_err   (s_meta_err),
        .busy       (s_busy),
        .pkt_count  (s_pkt),
        .err_count  (s_err)
    );

    typedef struct {
        logic [31:0] meta;
        logic        err;
        int          pkt_cnt;
        int          err_cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   model_pkt = 0;
    int   model_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && meta_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse: meta_out %h at cycle %0d, expected no pulse", meta_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("meta_out", meta_out, e.meta);
                check("meta_err", {31'b0, meta_err}, {31'b0, e.err});
                check("pulse_cycle", cyc, e.cyc);
                check("pkt_count", {16'b0, pkt_count}, e.pkt_cnt);
                check("err_count", {16'b0, err_count}, e.err_cnt);
                check("busy_in_done", {31'b0, busy}, 32'd0);
                $display("pulse cyc=%0d meta_out=%h meta_err=%0b pkt_count=%0d err_count=%0d",
                         cyc, meta_out, meta_err, pkt_count, err_count);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pkt_valid = 1'b0;
        end
    endtask

    // Drive one word after 'gap' idle cycles; optionally confirm busy
    // each cycle beforehand (used while inside a payload).
    task automatic send(input logic [31:0] d, input int gap, input bit chk_busy);
        repeat (gap) begin
            @(posedge clk);
            #1;
            pkt_valid = 1'b0;
            if (chk_busy) check("busy_gap", {31'b0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        if (chk_busy) check("busy_word", {31'b0, busy}, 32'd1);
        pkt_valid = 1'b1;
        pkt_data  = d;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic push_exp(input logic [31:0] hdr, input logic err);
        exp_t e;
        model_pkt++;
        if (err) model_err++;
        e.meta    = hdr;
        e.err     = err;
        e.pkt_cnt = sat16(model_pkt);
        e.err_cnt = sat16(model_err);
        e.cyc     = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Send a full packet; word bad_k (if in range) is replaced by bad_val.
    task automatic send_pkt(input logic [31:0] hdr, input int bad_k,
                            input logic [31:0] bad_val, input int maxgap);
        int          len;
        logic        err;
        logic [31:0] w;
        logic [15:0] k16;
        len = int'(hdr[27:20]);
        err = (hdr[29:28] != 2'd0);
        send(hdr, 0, 1'b0);
        if (len == 0) push_exp(hdr, err);
        for (int k = 0; k < len; k++) begin
            k16 = k[15:0];
            w = {hdr[15:0], k16};
            if (k == bad_k) begin
                if (bad_val != w) err = 1'b1;
                w = bad_val;
            end
            send(w, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 1'b1);
            if (k == len - 1) push_exp(hdr, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_meta_valid", {31'b0, meta_valid}, 32'd0);
        check("rst_meta_out", meta_out, 32'd0);
        check("rst_meta_err", {31'b0, meta_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_pkt_count", {16'b0, pkt_count}, 32'd0);
        check("rst_err_count", {16'b0, err_count}, 32'd0);

        // Good len-3 packet.
        send_pkt(32'h0030_0005, -1, 32'h0, 0);
        idle(3);
        // Same packet, payload word 1 corrupted.
        send_pkt(32'h0030_0005, 1, 32'h0005_00FF, 0);
        idle(3);
        // Wrong destination with correct payload.
        send_pkt(32'h2010_0001, -1, 32'h0, 0);
        idle(3);
        // Back-to-back: len0 header then len2 packet.
        send_pkt(32'h0000_0010, -1, 32'h0, 0);
        send_pkt(32'h0020_0011, -1, 32'h0, 0);
        idle(3);
        // len 255 with random gaps.
        send_pkt(32'h0FF0_0042, -1, 32'h0, 5);
        idle(4);

        // Reset after 2 of 4 payload words.
        send(32'h0040_0007, 0, 1'b0);
        send(32'h0007_0000, 0, 1'b1);
        send(32'h0007_0001, 0, 1'b1);
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_pkt = 0;
        model_err = 0;
        check("abort_pkt_count", {16'b0, pkt_count}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        idle(3);
        send_pkt(32'h0010_0009, -1, 32'h0, 0);
        idle(3);
        check("fresh_pkt_count", {16'b0, pkt_count}, 32'd1);

        // Narrow-counter instance: dst match, then saturation burst.
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 32'h1000_0000;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("sat_meta_valid", {31'b0, s_meta_valid}, 32'd1);
        check("sat_meta_err", {31'b0, s_meta_err}, 32'd0);
        check("sat_pkt_one", {29'b0, s_pkt}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = 32'h0000_0000;
        repeat (10) @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sat_pkt_count", {29'b0, s_pkt}, 32'd7);
        check("sat_err_count", {29'b0, s_err}, 32'd7);

        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (exp_q.size() != 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL missing_pulse: %0d outstanding, expected 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
